// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: bank geometry, word types and the copy-engine state encoding.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 2 ** DMEM_ADDR_W;

    typedef logic [DMEM_ADDR_W-1:0] dmem_addr_t;
    typedef logic [DMEM_DATA_W-1:0] dmem_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

endpackage

// File: rtl/dmem_copy_ctr.sv
// Address and length bookkeeping for the copy engine: wrapping src/dst incrementers and a
// remaining-word down-counter with a zero flag.
module dmem_copy_ctr
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [CNT_W-1:0]  len_in,
    input  logic              step_src,
    input  logic              step_dst,
    output logic [ADDR_W-1:0] cur_src,
    output logic [ADDR_W-1:0] cur_dst,
    output logic [CNT_W-1:0]  remaining,
    output logic              rem_zero
);

    // Address increments wrap naturally at 2**ADDR_W; step_src consumes one word of length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_src   <= src_in;
            cur_dst   <= dst_in;
            remaining <= len_in;
        end else begin
            if (step_src) begin
                cur_src   <= cur_src + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
            if (step_dst) begin
                cur_dst <= cur_dst + ADDR_W'(1);
            end
        end
    end

    assign rem_zero = (remaining == '0);

endmodule

// File: rtl/dmem_copy_engine.sv
// Forward block mover for the data memory bank: READ/WRITE pairs, two cycles per word.
// Optional macro DMEM_COPY_CHECKSUM_EN adds a running sum of every word read.
module dmem_copy_engine
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int MAX_LEN = 2 ** ADDR_W;
    localparam int CNT_W   = ADDR_W + 1;

    copy_state_t       state, state_d;
    logic              memread_d, memwrite_d;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] writedata_d;
    logic [CNT_W-1:0]  len_clamped;
    logic [ADDR_W-1:0] cur_src, cur_dst;
    logic [CNT_W-1:0]  remaining;
    logic              rem_zero;
    logic              accept;

    // Lengths beyond the bank depth would just recopy words, so they saturate at one full pass.
    always_comb begin
        if (int'(len) > MAX_LEN) len_clamped = CNT_W'(MAX_LEN);
        else                     len_clamped = CNT_W'(len);
    end

    assign accept = (state == IDLE) && start;

    dmem_copy_ctr #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .src_in    (src_addr),
        .dst_in    (dst_addr),
        .len_in    (len_clamped),
        .step_src  (state == READ),
        .step_dst  (state == WRITE),
        .cur_src   (cur_src),
        .cur_dst   (cur_dst),
        .remaining (remaining),
        .rem_zero  (rem_zero)
    );

    // State and memory-side output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            address   <= '0;
            writedata <= '0;
        end else begin
            state     <= state_d;
            memread   <= memread_d;
            memwrite  <= memwrite_d;
            address   <= address_d;
            writedata <= writedata_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = (len == '0) ? DONE : READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = rem_zero ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered bus outputs; writedata doubles as the read holding register.
    always_comb begin
        memread_d   = 1'b0;
        memwrite_d  = 1'b0;
        address_d   = address;
        writedata_d = writedata;
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    memread_d = 1'b1;
                    address_d = src_addr;
                end
            end
            READ: begin
                memwrite_d  = 1'b1;
                address_d   = cur_dst;
                writedata_d = readdata;
            end
            WRITE: begin
                if (!rem_zero) begin
                    memread_d = 1'b1;
                    address_d = cur_src;
                end
            end
            DONE:    address_d = '0;
            default: address_d = '0;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef DMEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              checksum <= '0;
        else if (accept)         checksum <= '0;
        else if (state == READ)  checksum <= checksum + readdata;
    end
`endif

endmodule
